// File: rtl/pc_branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pc_branch_ctrl
// Description : Program counter and branch-redirect stage. Resolves B/BR
//               branches in ID, retargets the PC, squashes wrong-path
//               instructions with a multi-cycle flush and freezes on HALT.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_branch_ctrl #(
    parameter int PC_W      = 16,
    parameter int OFF_W     = 9,
    parameter int FLUSH_CYC = 1     // legal range 1..7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch,
    input  logic             branch_reg,
    input  logic             cond_true,
    input  logic             halt_id,
    input  logic [OFF_W-1:0] imm_off,
    input  logic [PC_W-1:0]  reg_target,
    input  logic [PC_W-1:0]  id_pc_plus2,
    output logic [PC_W-1:0]  pc,
    output logic [PC_W-1:0]  pc_plus2,
    output logic             flush,
    output logic             halted,
    output logic [15:0]      taken_cnt
);

    localparam logic [1:0]      c_st_run    = 2'd0;
    localparam logic [1:0]      c_st_flush  = 2'd1;
    localparam logic [1:0]      c_st_halt   = 2'd2;
    localparam logic [2:0]      c_flush_init = 3'(FLUSH_CYC);
    localparam logic [2:0]      c_flush_last = 3'd1;
    localparam logic [15:0]     c_cnt_max   = 16'hFFFF;
    localparam logic [PC_W-1:0] c_pc_step   = PC_W'(2);
    // Clears bit 0 so register targets are always instruction aligned.
    localparam logic [PC_W-1:0] c_align_mask = ~(PC_W'(1));

    logic [1:0]      r_state;
    logic [2:0]      r_flush_left;
    logic [PC_W-1:0] r_pc;
    logic [15:0]     r_taken_cnt;

    logic [PC_W-1:0] w_off_sext;
    logic [PC_W-1:0] w_off_bytes;
    logic [PC_W-1:0] w_b_target;
    logic [PC_W-1:0] w_br_target;
    logic [PC_W-1:0] w_target;
    logic            w_take;

    // Word offset is sign-extended then scaled to bytes; wraps modulo 2^PC_W.
    assign w_off_sext  = {{(PC_W-OFF_W){imm_off[OFF_W-1]}}, imm_off};
    assign w_off_bytes = {w_off_sext[PC_W-2:0], 1'b0};
    assign w_b_target  = id_pc_plus2 + w_off_bytes;
    assign w_br_target = reg_target & c_align_mask;

    // B wins over BR when both are decoded (illegal, but deterministic).
    assign w_target = branch ? w_b_target : w_br_target;

    // cond_true is masked by the branch decodes, so it never leaks in otherwise.
    assign w_take = (branch | branch_reg) & cond_true;

    assign pc        = r_pc;
    assign pc_plus2  = r_pc + c_pc_step;
    assign taken_cnt = r_taken_cnt;

    // Moore outputs decoded from the registered state only.
    assign flush  = (r_state == c_st_flush);
    assign halted = (r_state == c_st_halt);

    // PC, redirect FSM, flush countdown and taken-branch counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_run;
            r_flush_left <= 3'd0;
            r_pc         <= '0;
            r_taken_cnt  <= 16'd0;
        end else begin
            case (r_state)
                c_st_run: begin
                    if (!stall) begin
                        if (halt_id) begin
                            // Halt outranks a simultaneous taken branch; pc holds.
                            r_state <= c_st_halt;
                        end else if (w_take) begin
                            r_pc         <= w_target;
                            r_state      <= c_st_flush;
                            r_flush_left <= c_flush_init;
                            if (r_taken_cnt != c_cnt_max) begin
                                r_taken_cnt <= r_taken_cnt + 16'd1;
                            end
                        end else begin
                            r_pc <= pc_plus2;
                        end
                    end
                end
                c_st_flush: begin
                    // ID holds a wrong-path instruction: its decodes are ignored.
                    if (!stall) begin
                        r_pc <= pc_plus2;
                        if (r_flush_left <= c_flush_last) begin
                            r_state <= c_st_run;
                        end else begin
                            r_flush_left <= r_flush_left - 3'd1;
                        end
                    end
                end
                c_st_halt: begin
                    // Frozen until reset.
                    r_state <= c_st_halt;
                end
                default: begin
                    r_state <= c_st_run;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_branch_ctrl
// Description : Randomised and directed bench for pc_branch_ctrl with a
//               queue-based scoreboard fed by a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_branch_ctrl;

    localparam int c_pc_w  = 16;
    localparam int c_off_w = 9;
    localparam int c_flush = 3;

    logic              clk = 1'b0;
    logic              rst, stall, branch, branch_reg, cond_true, halt_id;
    logic [c_off_w-1:0] imm_off;
    logic [c_pc_w-1:0]  reg_target, id_pc_plus2;
    logic [c_pc_w-1:0]  pc, pc_plus2;
    logic              flush, halted;
    logic [15:0]       taken_cnt;

    pc_branch_ctrl #(.PC_W(c_pc_w), .OFF_W(c_off_w), .FLUSH_CYC(c_flush)) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch(branch),
        .branch_reg(branch_reg), .cond_true(cond_true), .halt_id(halt_id),
        .imm_off(imm_off), .reg_target(reg_target), .id_pc_plus2(id_pc_plus2),
        .pc(pc), .pc_plus2(pc_plus2), .flush(flush), .halted(halted),
        .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pc;
        int pc2;
        int flush;
        int halted;
        int cnt;
    } exp_t;

    exp_t q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    // Behavioural model: plain integers, flush expressed as cycles remaining.
    int m_pc, m_left, m_halted, m_cnt;

    task automatic chk(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit s, input bit b, input bit br,
                              input bit c, input bit h, input int off,
                              input int regt, input int idpc);
        int o;
        if (r) begin
            m_pc = 0; m_left = 0; m_halted = 0; m_cnt = 0;
        end else if (m_halted != 0) begin
            // frozen
        end else if (m_left > 0) begin
            if (!s) begin
                m_pc = (m_pc + 2) & 16'hFFFF;
                m_left = m_left - 1;
            end
        end else if (s) begin
            // hold
        end else if (h) begin
            m_halted = 1;
        end else if ((b || br) && c) begin
            if (b) begin
                o = off;
                if (o >= 256) o = o - 512;
                m_pc = (idpc + 2 * o) & 16'hFFFF;
            end else begin
                m_pc = regt - (regt % 2);
            end
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
            m_left = c_flush;
        end else begin
            m_pc = (m_pc + 2) & 16'hFFFF;
        end
    endtask

    // Drive one cycle of inputs at negedge and queue the post-edge expectation.
    task automatic drive(input bit r, input bit s, input bit b, input bit br,
                         input bit c, input bit h, input int off,
                         input int regt, input int idpc);
        exp_t e;
        rst = r; stall = s; branch = b; branch_reg = br; cond_true = c;
        halt_id = h; imm_off = off[8:0]; reg_target = regt[15:0];
        id_pc_plus2 = idpc[15:0];
        model_step(r, s, b, br, c, h, off, regt, idpc);
        e.pc = m_pc; e.pc2 = (m_pc + 2) & 16'hFFFF;
        e.flush = (m_left > 0) ? 1 : 0;
        e.halted = m_halted; e.cnt = m_cnt;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rand_cycle(input bit allow_rst);
        bit r;
        r = allow_rst && ($urandom_range(0, 39) == 0);
        drive(r, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 59) == 0, int'($urandom_range(0, 511)),
              int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
    endtask

    // Monitor: the DUT presents a result every cycle; compare just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc",        int'(pc),        e.pc);
                chk("pc_plus2",  int'(pc_plus2),  e.pc2);
                chk("flush",     int'(flush),     e.flush);
                chk("halted",    int'(halted),    e.halted);
                chk("taken_cnt", int'(taken_cnt), e.cnt);
            end
        end
    end

    initial begin
        rst = 1; stall = 0; branch = 0; branch_reg = 0; cond_true = 0;
        halt_id = 0; imm_off = '0; reg_target = '0; id_pc_plus2 = '0;
        m_pc = 0; m_left = 0; m_halted = 0; m_cnt = 0;
        @(negedge clk);

        // Reset, then free-running fetch: 0, 2, 4, 6.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(4);

        // B: 0x0010 + (-4 words) = 0x0008; branch during flush is ignored,
        // and cond_true without a branch decode does nothing.
        drive(0, 0, 1, 0, 1, 0, 9'h1FC, 0, 16'h0010);
        drive(0, 0, 1, 0, 1, 1, 9'h010, 0, 16'h0100);
        drive(0, 0, 0, 1, 1, 0, 0, 16'h5555, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
        idle(2);

        // BR to 0x1235 -> 0x1234 with a stall in the 2nd flush cycle.
        drive(0, 0, 0, 1, 1, 0, 0, 16'h1235, 0);
        drive(0, 0, 1, 0, 1, 0, 9'h0FF, 0, 16'h2000);
        drive(0, 1, 1, 0, 1, 0, 9'h0FF, 0, 16'h2000);
        idle(3);

        // Stall with take in RUN: no redirect until the stall drops.
        drive(0, 1, 0, 1, 1, 0, 0, 16'h0400, 0);
        drive(0, 0, 0, 1, 1, 0, 0, 16'h0400, 0);
        idle(c_flush);

        // Both decodes high: B target wins.
        drive(0, 0, 1, 1, 1, 0, 9'h004, 16'h7000, 16'h0300);
        idle(c_flush);

        // Reach 0xFFFE, then a not-taken branch wraps the PC to 0x0000.
        drive(0, 0, 0, 1, 1, 0, 0, 16'hFFF8, 0);
        idle(c_flush);
        drive(0, 0, 1, 0, 0, 0, 9'h020, 0, 16'h1000);
        idle(2);

        // Halt together with a taken branch at 0x0040; ignore everything after.
        drive(0, 0, 0, 1, 1, 0, 0, 16'h003A, 0);
        idle(c_flush);
        drive(0, 0, 0, 1, 1, 1, 0, 16'h8000, 0);
        for (int i = 0; i < 12; i++) rand_cycle(0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Saturation: preload the counter close to the top while stalled.
        force dut.r_taken_cnt = 16'hFFF0;
        m_cnt = 16'hFFF0;
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        release dut.r_taken_cnt;
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 0, 1, 1, 0, 0, int'($urandom_range(0, 65535)), 0);
            idle(c_flush);
        end

        // Randomised traffic, including resets to escape HALT.
        for (int i = 0; i < 3000; i++) rand_cycle(1);

        @(posedge clk);
        #2;
        chk("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_branch_ctrl.md
# pc_branch_ctrl

Program-counter and branch-redirect stage for the CPU. It sits directly downstream of the condition-code evaluator and consumes that evaluator's `cond_true`. On a taken branch it retargets the PC, squashes wrong-path instructions with a multi-cycle flush, and freezes fetch on HALT. All branches resolve in ID; the PC feeds instruction memory in IF.

## Interface
Parameters:
- `PC_W`, 16, PC and target width in bits; byte-addressed, 16-bit instructions.
- `OFF_W`, 9, width of the signed word offset carried by `B` instructions.
- `FLUSH_CYC`, 1, number of cycles `flush` is held after a redirect; legal range 1..7.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hazard-unit stall; PC, branch and halt handling frozen.
- `branch`  in  1  ID instruction is `B` (PC-relative).
- `branch_reg`  in  1  ID instruction is `BR` (register target).
- `cond_true`  in  1  condition result from the evaluator for the ID instruction.
- `halt_id`  in  1  ID instruction is HLT.
- `imm_off`  in  OFF_W  signed word offset from `B`.
- `reg_target`  in  PC_W  `BR` target register value.
- `id_pc_plus2`  in  PC_W  PC+2 of the ID instruction.
- `pc`  out  PC_W  fetch address.
- `pc_plus2`  out  PC_W  `pc + 2`, modulo 2^PC_W; combinational from `pc`.
- `flush`  out  1  squash the IF/ID register.
- `halted`  out  1  core halted.
- `taken_cnt`  out  16  saturating count of taken redirects.

## Operation
- `take = (branch | branch_reg) & cond_true`.
- `cond_true` is only meaningful while `branch` or `branch_reg` is high. The unit must not use it otherwise.
- Target for `B`: `id_pc_plus2 + (sext(imm_off) << 1)`, truncated to PC_W.
- Target for `BR`: `{reg_target[PC_W-1:1], 1'b0}`; bit 0 is forced to 0.
- If `branch` and `branch_reg` are both high, `B` wins. This is an illegal decode and is handled deterministically.
- FSM states and transitions:
  - RUN:
    - If `stall`: hold everything.
    - Else if `halt_id`: go to HALT; `pc` holds. Halt has priority over branch.
    - Else if `take`: `pc` <= target, `taken_cnt`++, go to FLUSH, load the flush counter with FLUSH_CYC.
    - Else: `pc` <= `pc_plus2`.
  - FLUSH:
    - `flush` = 1.
    - `branch`, `branch_reg` and `halt_id` are ignored, because the ID instruction is wrong-path.
    - If `~stall`: `pc` <= `pc_plus2` and the counter decrements.
    - When the counter reaches 1 with `~stall`, go to RUN.
    - If `stall`: counter and `pc` hold.
  - HALT:
    - `halted` = 1, `pc` frozen.
    - `stall` and all other inputs are ignored.
    - Only `rst` exits HALT.
- `taken_cnt` saturates at 0xFFFF.
- `pc` wraps: 0xFFFE + 2 gives 0x0000.
- `flush` and `halted` are Moore outputs of the registered state, never combinational from the inputs.

## Timing
- Reset: `pc` = 0, state = RUN, `flush` = 0, `halted` = 0, `taken_cnt` = 0.
- Reset applies at the edge where `rst` = 1 and overrides every other input, including mid-FLUSH and in HALT.
- Redirect latency:
  - Target appears on `pc` at edge N+1 after the resolving cycle N.
  - `flush` is high in cycles N+1 .. N+FLUSH_CYC, stretched by any stall cycles.
- Halt latency: with HLT in ID in cycle N and `~stall`, `halted` = 1 from N+1. `pc` is the same value in N and N+1.
- Simultaneous events:
  - `stall` together with `take` in RUN: no redirect that cycle. The same instruction re-resolves when the stall drops.
  - `halt_id` together with `take`: HALT; `taken_cnt` unchanged.
- Single-cycle throughput: a new branch may resolve in the first RUN cycle after FLUSH ends.

## Test plan
- Reset, then 4 free-running cycles -> `pc` = 0, 2, 4, 6; `flush` = 0; `halted` = 0.
- `B` with `id_pc_plus2` = 0x0010, `imm_off` = 9'h1FC (−4), `cond_true` = 1 -> next `pc` = 0x0008; `flush` = 1 for 1 cycle (FLUSH_CYC = 1); `taken_cnt` = 1.
- `BR` with `reg_target` = 0x1235, `cond_true` = 1, FLUSH_CYC = 3, `stall` high in the 2nd flush cycle -> `pc` = 0x1234; `flush` high for 4 cycles; a `branch` asserted during flush is ignored.
- `branch` = 1, `cond_true` = 0 at `pc` = 0xFFFE -> `pc` = 0x0000, no flush; `taken_cnt` unchanged.
- `halt_id` with `take` and `stall` = 0 at `pc` = 0x0040 -> `halted` = 1, `pc` stays 0x0040 for 10+ cycles; `rst` -> `pc` = 0, `halted` = 0.
- 65,540 taken branches -> `taken_cnt` holds 0xFFFF.
